// File: rtl/sseg_pkg.sv
// Shared types and glyph constants for 7-segment readback.
// Segment order: bit0 top .. bit5 upper-left, bit6 middle.
package sseg_pkg;

  typedef logic [6:0] sseg_t;

  localparam sseg_t SSEG_0     = 7'h3F;
  localparam sseg_t SSEG_1     = 7'h06;
  localparam sseg_t SSEG_2     = 7'h5B;
  localparam sseg_t SSEG_3     = 7'h4F;
  localparam sseg_t SSEG_4     = 7'h66;
  localparam sseg_t SSEG_5     = 7'h6D;
  localparam sseg_t SSEG_6     = 7'h7D;
  localparam sseg_t SSEG_7     = 7'h07;
  localparam sseg_t SSEG_8     = 7'h7F;
  localparam sseg_t SSEG_9     = 7'h6F;
  localparam sseg_t SSEG_A     = 7'h77;
  localparam sseg_t SSEG_B     = 7'h7C;
  localparam sseg_t SSEG_C     = 7'h58;
  localparam sseg_t SSEG_D     = 7'h5E;
  localparam sseg_t SSEG_E     = 7'h79;
  localparam sseg_t SSEG_F     = 7'h71;
  localparam sseg_t SSEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    WAIT,
    DECODE,
    OUT
  } state_t;

endpackage

// File: rtl/sseg2num.sv
// Single-digit 7-segment to nibble decoder.
// Exact glyph match only; blank and illegal patterns flagged.
module sseg2num
  import sseg_pkg::*;
(
  input  sseg_t      seg,
  output logic [3:0] nib,
  output logic       err,
  output logic       blank
);

  always_comb begin
    nib   = 4'h0;
    err   = 1'b0;
    blank = 1'b0;
    unique case (1'b1)
      (seg == SSEG_0):     nib = 4'h0;
      (seg == SSEG_1):     nib = 4'h1;
      (seg == SSEG_2):     nib = 4'h2;
      (seg == SSEG_3):     nib = 4'h3;
      (seg == SSEG_4):     nib = 4'h4;
      (seg == SSEG_5):     nib = 4'h5;
      (seg == SSEG_6):     nib = 4'h6;
      (seg == SSEG_7):     nib = 4'h7;
      (seg == SSEG_8):     nib = 4'h8;
      (seg == SSEG_9):     nib = 4'h9;
      (seg == SSEG_A):     nib = 4'hA;
      (seg == SSEG_B):     nib = 4'hB;
      (seg == SSEG_C):     nib = 4'hC;
      (seg == SSEG_D):     nib = 4'hD;
      (seg == SSEG_E):     nib = 4'hE;
      (seg == SSEG_F):     nib = 4'hF;
      (seg == SSEG_BLANK): blank = 1'b1;
      default:             err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg2num_capture.sv
// Captures stable HEX display patterns and decodes them
// one digit per cycle into a word on a valid/ready port.
module sseg2num_capture
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] sseg_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic [NUM_DIGITS-1:0]   out_blank
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);

  state_t                  state, nstate;
  logic [7*NUM_DIGITS-1:0] snap;
  logic [CW-1:0]           cnt;
  logic                    reported, dirty;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] acc_val, acc_val_n;
  logic [NUM_DIGITS-1:0]   acc_err, acc_err_n;
  logic [NUM_DIGITS-1:0]   acc_blk, acc_blk_n;
  sseg_t                   cur;
  logic [3:0]              nib;
  logic                    d_err, d_blk;
  logic                    chg, full, last;

  assign chg  = (sseg_in != snap);
  assign full = (cnt == FULL);
  assign last = (idx == LAST);

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IW'(i)) cur = snap[7*i +: 7];
  end

  sseg2num u_dec (
    .seg   (cur),
    .nib   (nib),
    .err   (d_err),
    .blank (d_blk)
  );

  always_comb begin
    acc_val_n = acc_val;
    acc_err_n = acc_err;
    acc_blk_n = acc_blk;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IW'(i)) begin
        acc_val_n[4*i +: 4] = nib;
        acc_err_n[i]        = d_err;
        acc_blk_n[i]        = d_blk;
      end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      WAIT:
        if (full && !reported && !chg)
          nstate = DECODE;
      DECODE:
        if (chg)       nstate = WAIT;
        else if (last) nstate = OUT;
      OUT:
        if (out_ready) nstate = WAIT;
      default: nstate = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      cnt       <= '0;
      reported  <= 1'b0;
      dirty     <= 1'b0;
      idx       <= '0;
      acc_val   <= '0;
      acc_err   <= '0;
      acc_blk   <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= '0;
      out_blank <= '0;
    end else begin
      snap <= sseg_in;
      if (chg) begin
        cnt      <= '0;
        reported <= 1'b0;
      end else if (!full) begin
        cnt <= cnt + 1'b1;
      end
      case (state)
        WAIT:
          if (nstate == DECODE) begin
            idx     <= '0;
            acc_val <= '0;
            acc_err <= '0;
            acc_blk <= '0;
            dirty   <= 1'b0;
          end
        DECODE:
          if (!chg) begin
            idx     <= idx + 1'b1;
            acc_val <= acc_val_n;
            acc_err <= acc_err_n;
            acc_blk <= acc_blk_n;
            if (last) begin
              out_value <= acc_val_n;
              out_err   <= acc_err_n;
              out_blank <= acc_blk_n;
              out_valid <= 1'b1;
            end
          end
        OUT: begin
          // a change while held means the display must be re-captured
          if (chg) dirty <= 1'b1;
          if (out_ready) begin
            out_valid <= 1'b0;
            reported  <= !(dirty || chg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sseg2num_capture.md
Name: sseg2num_capture

Overview:
Reads back the 7-segment patterns driven onto the virtual board's HEX displays and recovers the hex digits they show. The block waits until all displays have been stable for a set number of cycles. It then decodes them one digit per cycle and presents the full word, plus per-digit error and blank flags, on a valid/ready interface. It sits on the bench and monitor side of the display path, as the inverse of the digit-to-segment encoding.

Parameters:
NUM_DIGITS, 6, number of 7-segment displays captured (1..8).
STABLE_CYCLES, 4, consecutive unchanged cycles required before decoding (>=1).

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
sseg_in  in  7*NUM_DIGITS  segment patterns; digit i at [7i+6:7i]; active-high; bit0=top, 1=upper-right, 2=lower-right, 3=bottom, 4=lower-left, 5=upper-left, 6=middle.
out_valid  out  1  captured word available.
out_ready  in  1  consumer accepts word.
out_value  out  4*NUM_DIGITS  decoded nibble of digit i at [4i+3:4i].
out_err  out  NUM_DIGITS  bit i=1: digit i pattern is not a legal glyph.
out_blank  out  NUM_DIGITS  bit i=1: digit i pattern is 7'h00.

Behaviour:
- Reset (async assert, sync deassert use): state=WAIT, out_valid=0, out_value=0, out_err=0, out_blank=0, stability counter=0, snapshot=0, reported=0.
- Snapshot register samples sseg_in every cycle.
- Stability counter:
  - Clears when sseg_in != snapshot; this also clears reported.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Decode table (pattern->nibble), exact match only:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
  - 77->A, 7C->B, 58->C, 5E->D, 79->E, 71->F.
  - 00 -> nibble 0, blank=1, err=0.
  - Any other pattern -> nibble 0, err=1, blank=0.
- FSM:
  - WAIT: when counter==STABLE_CYCLES and reported==0 -> DECODE, digit index=0, accumulators cleared.
  - DECODE: each cycle, decode the snapshot digit at index into the accumulators, then index++. After digit NUM_DIGITS-1 is decoded -> OUT, loading out_* from the accumulators and setting out_valid=1.
  - DECODE abort: if sseg_in != snapshot during DECODE -> WAIT; accumulators are discarded and out_* remain unchanged.
  - OUT: out_valid=1 and out_* held stable until out_valid&&out_ready. On handshake: out_valid=0, reported=1 -> WAIT.
  - OUT input changes: changes on sseg_in during OUT do not alter the held word; they clear reported so the new pattern is captured afterwards.
- Latency: with sseg_in changing last at cycle t and out_ready=1, out_valid rises at cycle t+STABLE_CYCLES+NUM_DIGITS+1.
- A pattern is reported exactly once. An unchanged display never produces a second word.
- out_ready is ignored outside OUT, and out_valid never drops without a handshake.
- Reset mid-DECODE or mid-OUT: immediate return to reset values; the in-flight word is lost.
- Digit index width is clog2(NUM_DIGITS) with minimum 1. The counter width is clog2(STABLE_CYCLES+1).

Decomposition:
- Package sseg_pkg:
  - typedef sseg_t (logic [6:0]).
  - Constants SSEG_0..SSEG_F and SSEG_BLANK, using the values above.
  - State enum {WAIT, DECODE, OUT}.
- Sub-module sseg2num: combinational; inputs sseg_t; outputs nibble, err, blank; built on the package constants. Instantiated once and muxed by digit index.

Test Plan:
- Reset with sseg_in=0 held 20 cycles, out_ready=1: expect exactly one word, out_value=0, out_blank=6'h3F, out_err=0. Then expect no further words.
- Digits 0..5 = 06,5B,4F,66,6D,7D, out_ready=1: out_valid rises 4+6+1=11 cycles after the last change, out_value=24'h654321, out_err=0, out_blank=0.
- Digit 2 = 7'h7E, others 3F: out_value=24'h000000, out_err=6'b000100. Then hold with out_ready=0 for 10 cycles: out_valid and out_* stay stable. Raise out_ready: one handshake, then out_valid=0.
- Change digit 0 from 3F to 06 at DECODE index 3: no word from the aborted scan. One word with out_value[3:0]=1 appears 11 cycles after the change.
- Toggle sseg_in every 3 cycles (STABLE_CYCLES=4): out_valid never rises. Hold stable: one word.
- Assert rst_n=0 for 1 cycle while out_valid=1: out_valid=0 asynchronously. A stable input is re-captured after reset, 11 cycles later.
